// File: rtl/boot_pkg.sv
// boot_pkg: constants and encodings shared by the bootloader fetch stage and the verifier
package boot_pkg;
   localparam logic [31:0] BOOTLOADER_START = 32'h1000_0000;
   localparam int BOOTLOADER_WORDS = 1024;
   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_FLUSH, ST_DONE, ST_ERROR} fetch_state_t;
   typedef enum logic [1:0] {STAGE_FETCH, STAGE_LOAD, STAGE_HASH, STAGE_VERIFY} boot_stage_t;
endpackage

// File: rtl/boot_fetch_fifo.sv
// boot_fetch_fifo: synchronous FIFO with flush; the caller never pushes when full
// (unless also popping) and never pops when empty
module boot_fetch_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           flush,
   input  logic [31:0]                    din,
   output logic [31:0]                    dout,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [$clog2(DEPTH+1)-1:0] FULL_CNT = ($clog2(DEPTH+1))'(DEPTH);
   logic [31:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign full = count == FULL_CNT;
   assign empty = count == '0;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
      end
   end
endmodule

// File: rtl/bootloader_flash_fetch.sv
// bootloader_flash_fetch: streams the bootloader image from flash through a credit-limited
// FIFO onto a valid/ready stream, reporting flash timeouts and spurious responses
module bootloader_flash_fetch
   import boot_pkg::*;
#(
   parameter logic [31:0] START_ADDR     = BOOTLOADER_START,
   parameter int          NUM_WORDS      = BOOTLOADER_WORDS,
   parameter int          FIFO_DEPTH     = 4,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic [31:0] flash_addr,
   output logic        flash_read_en,
   input  logic [31:0] flash_data,
   input  logic        flash_data_valid,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic        error
);
   localparam int CW = $clog2(NUM_WORDS + 1);
   localparam int OW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] NW = CW'(NUM_WORDS);
   localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);
   localparam logic [OW:0] DEPTH = (OW+1)'(FIFO_DEPTH);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
   fetch_state_t state;
   logic [CW-1:0] issued, accepted;
   logic [OW-1:0] outstanding, out_nxt, fifo_count;
   logic [TW-1:0] tcnt;
   logic in_fetch, fifo_empty, fifo_full, resp, spurious, timeout, push, pop, flush;
   assign in_fetch = state == ST_FETCH;
   assign busy = in_fetch || state == ST_FLUSH;
   assign done = state == ST_DONE;
   assign error = state == ST_ERROR;
   assign resp = flash_data_valid && busy && outstanding != '0;
   assign spurious = flash_data_valid && in_fetch && outstanding == '0;
   assign timeout = busy && outstanding != '0 && !resp && tcnt == TLIM;
   // Credit counts both in-flight reads and buffered words, so the FIFO can never overflow
   assign flash_read_en = in_fetch && !abort && issued < NW &&
                          {1'b0, outstanding} + {1'b0, fifo_count} < DEPTH;
   assign push = resp && in_fetch && !abort && (!fifo_full || pop);
   assign pop = in_fetch && !abort && out_valid && out_ready;
   assign flush = in_fetch && (abort || timeout || spurious);
   assign out_valid = !fifo_empty;
   assign out_last = out_valid && accepted == LAST;
   assign out_nxt = flash_read_en && !resp ? outstanding + 1'b1 :
                    resp && !flash_read_en ? outstanding - 1'b1 : outstanding;
   boot_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .flush(flush),
      .din(flash_data),
      .dout(out_data),
      .full(fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         issued <= '0;
         accepted <= '0;
         outstanding <= '0;
         tcnt <= '0;
         flash_addr <= START_ADDR;
      end else begin
         outstanding <= out_nxt;
         tcnt <= (resp || !busy || outstanding == '0) ? '0 : tcnt + 1'b1;
         if (flash_read_en) begin
            issued <= issued + 1'b1;
            flash_addr <= flash_addr + 32'd4;
         end
         if (pop) accepted <= accepted + 1'b1;
         case (state)
            ST_FETCH: state <= abort ? ST_FLUSH : (timeout || spurious) ? ST_ERROR :
                               (pop && accepted == LAST) ? ST_DONE : ST_FETCH;
            ST_FLUSH: state <= timeout ? ST_ERROR : out_nxt == '0 ? ST_IDLE : ST_FLUSH;
            default: if (start && !abort) begin
               state <= ST_FETCH;
               issued <= '0;
               accepted <= '0;
               outstanding <= '0;
               flash_addr <= START_ADDR;
            end
         endcase
      end
   end
endmodule
